// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, word type and PC operation codes.
package cpu_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [DATA_W-1:0] word_t;

  // One resolved PC action per cycle, produced by the strobe priority decoder.
  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INCR,
    PC_LOAD,
    PC_CALL,
    PC_RET
  } pc_op_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address LIFO. A push while full and a pop while empty are ignored;
// the owner decides how to flag them. Entry contents are not reset.
module ras_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_top,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_depth
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] depth_q, depth_d;
  logic [PTR_W-1:0] wr_idx, top_idx;
  logic             do_push, do_pop;

  assign o_full  = (depth_q == CNT_W'(DEPTH));
  assign o_empty = (depth_q == '0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign wr_idx  = depth_q[PTR_W-1:0];
  assign top_idx = wr_idx - 1'b1;
  assign o_top   = mem_q[top_idx];
  assign o_depth = depth_q;

  // Depth counter next state: push and pop are never requested together.
  always_comb begin
    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + 1'b1;
    end else if (do_pop) begin
      depth_d = depth_q - 1'b1;
    end
  end

  // Depth register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge i_clk) begin
    if (!i_reset && do_push) begin
      mem_q[wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/program_counter.sv
// Fetch-address register with load/increment strobes, bus drive and a small
// hardware return-address stack for call/ret microcode.
module program_counter
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH       = DATA_W,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [WIDTH-1:0]               i_bus,
  input  logic                           i_ctrlLoadPC,
  input  logic                           i_ctrlIncrPC,
  input  logic                           i_ctrlPCNOe,
  input  logic                           i_ctrlCall,
  input  logic                           i_ctrlRet,
  input  logic                           i_hlt,
  output logic [WIDTH-1:0]               o_address,
  output logic [WIDTH-1:0]               o_bus,
  output logic                           o_busNoe,
  output logic [$clog2(STACK_DEPTH):0]   o_stackDepth,
  output logic                           o_stackErr
);

  pc_op_e           op;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stk_top;
  logic             stk_full, stk_empty;
  logic             stk_push, stk_pop;

  // Strobe priority: hlt > ret > call > load > incr.
  always_comb begin
    op = PC_HOLD;
    if (i_hlt) begin
      op = PC_HOLD;
    end else if (i_ctrlRet) begin
      op = PC_RET;
    end else if (i_ctrlCall) begin
      op = PC_CALL;
    end else if (i_ctrlLoadPC) begin
      op = PC_LOAD;
    end else if (i_ctrlIncrPC) begin
      op = PC_INCR;
    end
  end

  assign stk_push = (op == PC_CALL);
  assign stk_pop  = (op == PC_RET);

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_ras (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (stk_push),
    .i_pop   (stk_pop),
    .i_data  (pc_q),
    .o_top   (stk_top),
    .o_full  (stk_full),
    .o_empty (stk_empty),
    .o_depth (o_stackDepth)
  );

  // Next PC and sticky error from the resolved operation.
  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    unique case (op)
      PC_INCR: pc_d = pc_q + 1'b1;
      PC_LOAD: pc_d = i_bus;
      PC_CALL: begin
        pc_d = i_bus;
        if (stk_full) err_d = 1'b1;
      end
      PC_RET: begin
        if (stk_empty) begin
          err_d = 1'b1;
        end else begin
          pc_d = stk_top;
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  // PC and error registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign o_address  = pc_q;
  assign o_bus      = pc_q;
  assign o_busNoe   = i_ctrlPCNOe;
  assign o_stackErr = err_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter.
module tb_program_counter;

  localparam int unsigned W  = 8;
  localparam int unsigned DW = 3;

  logic          clk = 1'b0;
  logic          reset, load, incr, pcnoe, call, ret, hlt;
  logic [W-1:0]  bus_in;
  logic [W-1:0]  address, bus_out;
  logic          bus_noe, stack_err;
  logic [DW-1:0] stack_depth;

  int total = 0;
  int bad   = 0;

  program_counter #(
    .WIDTH       (8),
    .STACK_DEPTH (4)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_bus        (bus_in),
    .i_ctrlLoadPC (load),
    .i_ctrlIncrPC (incr),
    .i_ctrlPCNOe  (pcnoe),
    .i_ctrlCall   (call),
    .i_ctrlRet    (ret),
    .i_hlt        (hlt),
    .o_address    (address),
    .o_bus        (bus_out),
    .o_busNoe     (bus_noe),
    .o_stackDepth (stack_depth),
    .o_stackErr   (stack_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    reset = 0; load = 0; incr = 0; call = 0; ret = 0; hlt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); pcnoe = 1; bus_in = 8'h5A; reset = 1;
    tick();
    reset = 0;
    total++; if (address !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h exp=00", address); end
    total++; if (stack_depth !== 3'd0) begin bad++; $display("FAIL reset_depth got=%0d exp=0", stack_depth); end
    total++; if (stack_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", stack_err); end
  endtask

  task automatic test_incr();
    logic [W-1:0] exp_pc [3];
    exp_pc[0] = 8'h01; exp_pc[1] = 8'h02; exp_pc[2] = 8'h03;
    incr = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (address !== exp_pc[i]) begin bad++; $display("FAIL incr_%0d got=%h exp=%h", i, address, exp_pc[i]); end
    end
    incr = 0; pcnoe = 0;
    #1;
    total++; if (bus_out !== 8'h03) begin bad++; $display("FAIL bus_drive got=%h exp=03", bus_out); end
    total++; if (bus_noe !== 1'b0) begin bad++; $display("FAIL bus_noe got=%b exp=0", bus_noe); end
    pcnoe = 1;
    #1;
    total++; if (bus_noe !== 1'b1) begin bad++; $display("FAIL bus_noe_off got=%b exp=1", bus_noe); end
  endtask

  task automatic test_wrap();
    bus_in = 8'hFF; load = 1;
    tick();
    load = 0;
    total++; if (address !== 8'hFF) begin bad++; $display("FAIL load_ff got=%h exp=ff", address); end
    incr = 1;
    tick();
    incr = 0;
    total++; if (address !== 8'h00) begin bad++; $display("FAIL wrap got=%h exp=00", address); end
    total++; if (stack_err !== 1'b0) begin bad++; $display("FAIL wrap_err got=%b exp=0", stack_err); end
  endtask

  task automatic test_load_incr();
    bus_in = 8'h40; load = 1; incr = 1;
    tick();
    load = 0; incr = 0;
    total++; if (address !== 8'h40) begin bad++; $display("FAIL load_incr got=%h exp=40", address); end
  endtask

  task automatic test_call_ret();
    bus_in = 8'h10; load = 1;
    tick();
    load = 0; bus_in = 8'h80; call = 1;
    tick();
    call = 0;
    total++; if (address !== 8'h80) begin bad++; $display("FAIL call_pc got=%h exp=80", address); end
    total++; if (stack_depth !== 3'd1) begin bad++; $display("FAIL call_depth got=%0d exp=1", stack_depth); end
    incr = 1;
    tick();
    incr = 0;
    total++; if (address !== 8'h81) begin bad++; $display("FAIL call_incr got=%h exp=81", address); end
    ret = 1;
    tick();
    ret = 0;
    total++; if (address !== 8'h10) begin bad++; $display("FAIL ret_pc got=%h exp=10", address); end
    total++; if (stack_depth !== 3'd0) begin bad++; $display("FAIL ret_depth got=%0d exp=0", stack_depth); end
    // Call and Ret together: ret wins, so the pushed 0x10 is returned to from 0x55.
    bus_in = 8'h55; call = 1;
    tick();
    bus_in = 8'h99; ret = 1;
    tick();
    call = 0; ret = 0;
    total++; if (address !== 8'h10) begin bad++; $display("FAIL callret_pc got=%h exp=10", address); end
    total++; if (stack_depth !== 3'd0) begin bad++; $display("FAIL callret_depth got=%0d exp=0", stack_depth); end
    total++; if (stack_err !== 1'b0) begin bad++; $display("FAIL callret_err got=%b exp=0", stack_err); end
  endtask

  task automatic test_overflow_underflow();
    logic [W-1:0] ret_pc [5];
    reset = 1;
    tick();
    reset = 0; bus_in = 8'h20; load = 1;
    tick();
    load = 0;
    call = 1;
    for (int i = 0; i < 5; i++) begin
      bus_in = 8'hA0 + W'(i);
      tick();
    end
    call = 0;
    total++; if (address !== 8'hA4) begin bad++; $display("FAIL ovf_pc got=%h exp=a4", address); end
    total++; if (stack_depth !== 3'd4) begin bad++; $display("FAIL ovf_depth got=%0d exp=4", stack_depth); end
    total++; if (stack_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", stack_err); end
    ret_pc[0] = 8'hA2; ret_pc[1] = 8'hA1; ret_pc[2] = 8'hA0; ret_pc[3] = 8'h20; ret_pc[4] = 8'h20;
    ret = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (address !== ret_pc[i]) begin bad++; $display("FAIL ret_%0d_pc got=%h exp=%h", i, address, ret_pc[i]); end
      total++; if (stack_depth !== DW'((i < 4) ? 3 - i : 0)) begin
        bad++; $display("FAIL ret_%0d_depth got=%0d exp=%0d", i, stack_depth, (i < 4) ? 3 - i : 0);
      end
    end
    ret = 0;
    total++; if (stack_err !== 1'b1) begin bad++; $display("FAIL unf_err got=%b exp=1", stack_err); end
  endtask

  task automatic test_hlt_and_reset();
    // Underflow check on a freshly reset stack, then halt.
    reset = 1;
    tick();
    reset = 0; ret = 1;
    tick();
    ret = 0;
    total++; if (stack_err !== 1'b1) begin bad++; $display("FAIL empty_ret_err got=%b exp=1", stack_err); end
    bus_in = 8'h33; load = 1;
    tick();
    load = 0; bus_in = 8'h77; call = 1;
    tick();
    call = 0;
    hlt = 1; incr = 1; load = 1; call = 1; bus_in = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (address !== 8'h77) begin bad++; $display("FAIL hlt_pc_%0d got=%h exp=77", i, address); end
    end
    total++; if (stack_depth !== 3'd1) begin bad++; $display("FAIL hlt_depth got=%0d exp=1", stack_depth); end
    total++; if (stack_err !== 1'b1) begin bad++; $display("FAIL hlt_err got=%b exp=1", stack_err); end
    pcnoe = 0;
    #1;
    total++; if (bus_out !== 8'h77 || bus_noe !== 1'b0) begin
      bad++; $display("FAIL hlt_bus got=%h/%b exp=77/0", bus_out, bus_noe);
    end
    pcnoe = 1;
    hlt = 0; incr = 0; load = 0;
    bus_in = 8'hE0; reset = 1;
    tick();
    reset = 0; call = 0;
    total++; if (address !== 8'h00) begin bad++; $display("FAIL rst_call_pc got=%h exp=00", address); end
    total++; if (stack_depth !== 3'd0) begin bad++; $display("FAIL rst_call_depth got=%0d exp=0", stack_depth); end
    total++; if (stack_err !== 1'b0) begin bad++; $display("FAIL rst_call_err got=%b exp=0", stack_err); end
  endtask

  initial begin
    idle(); pcnoe = 1; bus_in = '0;
    #2;
    test_reset();
    test_incr();
    test_wrap();
    test_load_incr();
    test_call_ret();
    test_overflow_underflow();
    test_hlt_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
